// File: rtl/smg_pkg.sv
// Shared constants and types for the seven-segment display scheduler.
// Segment codes are active-high, bit 0 = A ... bit 6 = G, bit 7 = DP.
package smg_pkg;

  localparam logic [7:0] SegBlank = 8'h00;
  localparam logic [7:0] SegDash  = 8'h40;
  localparam logic [7:0] SegE     = 8'h79;
  localparam logic [7:0] SegZero  = 8'h3F;

  localparam logic [1:0] SigOff  = 2'b00;
  localparam logic [1:0] SigTens = 2'b01;
  localparam logic [1:0] SigOnes = 2'b10;

  typedef enum logic [2:0] {
    OwnTemp = 3'b001,
    OwnSet  = 3'b010,
    OwnErr  = 3'b100
  } owner_e;

  typedef enum logic [1:0] {
    CvIdle,
    CvConv,
    CvDone
  } conv_e;

  typedef enum logic [1:0] {
    ScOnes,
    ScBlank1,
    ScTens,
    ScBlank2
  } scan_e;

  // Anything outside 0..9 renders as a dash.
  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] seg;
    case (d)
      4'd0:    seg = 8'h3F;
      4'd1:    seg = 8'h06;
      4'd2:    seg = 8'h5B;
      4'd3:    seg = 8'h4F;
      4'd4:    seg = 8'h66;
      4'd5:    seg = 8'h6D;
      4'd6:    seg = 8'h7D;
      4'd7:    seg = 8'h07;
      4'd8:    seg = 8'h7F;
      4'd9:    seg = 8'h6F;
      default: seg = SegDash;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/smg_bin2dig.sv
// Sequential binary-to-decimal converter: repeated subtract-by-10, one step per cycle.
// start is accepted only in idle; done pulses for one cycle with tens/ones valid.
module smg_bin2dig
  import smg_pkg::*;
(
  input  logic       clk_1khz,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] value,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  conv_e      state_q, state_d;
  logic [6:0] res_q, res_d;
  logic [3:0] tens_q, tens_d;

  always_ff @(posedge clk_1khz or negedge rst) begin
    if (!rst) begin
      state_q <= CvIdle;
      res_q   <= '0;
      tens_q  <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      tens_q  <= tens_d;
    end
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    tens_d  = tens_q;
    unique case (state_q)
      CvIdle: begin
        if (start) begin
          state_d = CvConv;
          res_d   = value;
          tens_d  = '0;
        end
      end
      CvConv: begin
        if (res_q >= 7'd10) begin
          res_d  = res_q - 7'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          state_d = CvDone;
        end
      end
      default: state_d = CvIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != CvIdle);
    done = (state_q == CvDone);
    tens = tens_q;
    ones = res_q[3:0];
  end

endmodule

// File: rtl/smg_scheduler.sv
// Two-digit display owner: fixed-priority arbiter with hold time, digit registers
// fed by the shared converter, and the multiplexed scan with blanking gaps.
module smg_scheduler
  import smg_pkg::*;
#(
  parameter int unsigned HOLD_MS   = 2000,
  parameter int unsigned DIG_CYC   = 4,
  parameter int unsigned BLANK_CYC = 1
) (
  input  logic       clk_1khz,
  input  logic       rst,
  input  logic [6:0] temp_val,
  input  logic       set_req,
  input  logic [6:0] set_val,
  input  logic       err_req,
  input  logic [3:0] err_code,
  output logic [2:0] grant,
  output logic [1:0] smg_sig,
  output logic [7:0] smg_data
);

  localparam int unsigned HoldW   = (HOLD_MS > 2) ? $clog2(HOLD_MS) : 1;
  localparam int unsigned SlotMax = (DIG_CYC > BLANK_CYC) ? DIG_CYC : BLANK_CYC;
  localparam int unsigned CntW    = (SlotMax > 2) ? $clog2(SlotMax) : 1;

  owner_e           owner_q, owner_d;
  logic [HoldW-1:0] hold_q, hold_d;

  always_comb begin
    owner_d = owner_q;
    unique case (owner_q)
      OwnErr: begin
        if (!err_req && (hold_q == '0)) owner_d = set_req ? OwnSet : OwnTemp;
      end
      OwnSet: begin
        if (err_req) owner_d = OwnErr;
        else if (!set_req && (hold_q == '0)) owner_d = OwnTemp;
      end
      default: begin
        if (err_req) owner_d = OwnErr;
        else if (set_req) owner_d = OwnSet;
      end
    endcase

    hold_d = hold_q;
    if (owner_d != owner_q) hold_d = HoldW'(HOLD_MS - 1);
    else if (hold_q != '0) hold_d = hold_q - HoldW'(1);
  end

  always_ff @(posedge clk_1khz or negedge rst) begin
    if (!rst) begin
      owner_q <= OwnTemp;
      hold_q  <= '0;
    end else begin
      owner_q <= owner_d;
      hold_q  <= hold_d;
    end
  end

  assign grant = owner_q;

  logic [6:0] sel_val;
  logic       conv_start, conv_busy, conv_done;
  logic [3:0] conv_tens, conv_ones;
  logic [6:0] conv_val_q, last_conv_q;
  owner_e     conv_owner_q, disp_owner_q;
  logic [7:0] ones_seg_q, tens_seg_q;

  assign sel_val = (owner_q == OwnSet) ? set_val : temp_val;

  // disp_owner_q forces a fresh conversion when the owner changes but the value does not.
  assign conv_start = !conv_busy && (owner_q != OwnErr) &&
                      ((sel_val != last_conv_q) || (owner_q != disp_owner_q));

  smg_bin2dig u_bin2dig (
    .clk_1khz (clk_1khz),
    .rst      (rst),
    .start    (conv_start),
    .value    (sel_val),
    .busy     (conv_busy),
    .done     (conv_done),
    .tens     (conv_tens),
    .ones     (conv_ones)
  );

  always_ff @(posedge clk_1khz or negedge rst) begin
    if (!rst) begin
      conv_val_q   <= '0;
      conv_owner_q <= OwnTemp;
      last_conv_q  <= '0;
      disp_owner_q <= OwnTemp;
      ones_seg_q   <= SegZero;
      tens_seg_q   <= SegBlank;
    end else begin
      if (conv_start) begin
        conv_val_q   <= sel_val;
        conv_owner_q <= owner_q;
      end
      // Fault display bypasses the converter and wins over a late conversion result.
      if (owner_q == OwnErr) begin
        ones_seg_q   <= seg_of(err_code);
        tens_seg_q   <= SegE;
        disp_owner_q <= OwnErr;
      end else if (conv_done) begin
        last_conv_q  <= conv_val_q;
        disp_owner_q <= conv_owner_q;
        if (conv_val_q > 7'd99) begin
          ones_seg_q <= SegDash;
          tens_seg_q <= SegDash;
        end else begin
          ones_seg_q <= seg_of(conv_ones);
          tens_seg_q <= (conv_tens == 4'd0) ? SegBlank : seg_of(conv_tens);
        end
      end
    end
  end

  scan_e           scan_q, scan_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      slot_seg_q;
  logic            slot_end;

  always_ff @(posedge clk_1khz or negedge rst) begin
    if (!rst) begin
      scan_q     <= ScBlank2;
      cnt_q      <= '0;
      slot_seg_q <= SegBlank;
    end else begin
      scan_q <= scan_d;
      cnt_q  <= cnt_d;
      // Digit is latched on slot entry so the lit pattern is stable for the whole slot.
      if (slot_end && (scan_d == ScOnes)) slot_seg_q <= ones_seg_q;
      else if (slot_end && (scan_d == ScTens)) slot_seg_q <= tens_seg_q;
    end
  end

  always_comb begin
    if ((scan_q == ScOnes) || (scan_q == ScTens)) slot_end = (cnt_q == CntW'(DIG_CYC - 1));
    else slot_end = (cnt_q == CntW'(BLANK_CYC - 1));

    scan_d = scan_q;
    cnt_d  = cnt_q + CntW'(1);
    if (slot_end) begin
      cnt_d = '0;
      unique case (scan_q)
        ScOnes:   scan_d = ScBlank1;
        ScBlank1: scan_d = ScTens;
        ScTens:   scan_d = ScBlank2;
        default:  scan_d = ScOnes;
      endcase
    end
  end

  always_comb begin
    smg_sig  = SigOff;
    smg_data = SegBlank;
    unique case (scan_q)
      ScOnes: begin
        smg_sig  = SigOnes;
        smg_data = slot_seg_q;
      end
      ScTens: begin
        smg_sig  = SigTens;
        smg_data = slot_seg_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_smg_scheduler.sv
// Self-checking bench for smg_scheduler: scenario tasks plus an age-based ownership
// model and arithmetic digit expectations.
module tb_smg_scheduler;

  localparam int HOLD = 2000;

  logic       clk_1khz;
  logic       rst;
  logic [6:0] temp_val;
  logic       set_req;
  logic [6:0] set_val;
  logic       err_req;
  logic [3:0] err_code;
  logic [2:0] grant;
  logic [1:0] smg_sig;
  logic [7:0] smg_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  smg_scheduler #(
    .HOLD_MS   (HOLD),
    .DIG_CYC   (4),
    .BLANK_CYC (1)
  ) dut (
    .clk_1khz (clk_1khz),
    .rst      (rst),
    .temp_val (temp_val),
    .set_req  (set_req),
    .set_val  (set_val),
    .err_req  (err_req),
    .err_code (err_code),
    .grant    (grant),
    .smg_sig  (smg_sig),
    .smg_data (smg_data)
  );

  initial clk_1khz = 1'b0;
  always #5 clk_1khz = ~clk_1khz;

  // Edge count since reset release; ONES slots begin on edges 1, 11, 21, ...
  always @(posedge clk_1khz or negedge rst) begin
    if (!rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Ownership model: owner plus cycles owned, driven by the priority/hold rules.
  logic [2:0] m_owner;
  int         m_since;

  function automatic logic [2:0] arb_model(input logic [2:0] own, input logic e,
                                           input logic s, input int age);
    if (e && own != 3'b100) return 3'b100;
    if (s && own == 3'b001) return 3'b010;
    if (own == 3'b100 && !e && age >= HOLD) return s ? 3'b010 : 3'b001;
    if (own == 3'b010 && !s && age >= HOLD) return 3'b001;
    return own;
  endfunction

  always @(posedge clk_1khz or negedge rst) begin
    if (!rst) begin
      m_owner <= 3'b001;
      m_since <= 0;
    end else begin
      m_owner <= arb_model(m_owner, err_req, set_req, m_since);
      m_since <= (arb_model(m_owner, err_req, set_req, m_since) != m_owner) ? 1 : m_since + 1;
    end
  end

  function automatic logic [7:0] exp_ones(input int v);
    if (v > 99) return 8'h40;
    return seg_tab[v % 10];
  endfunction

  function automatic logic [7:0] exp_tens(input int v);
    if (v > 99) return 8'h40;
    if (v / 10 == 0) return 8'h00;
    return seg_tab[v / 10];
  endfunction

  function automatic logic [7:0] exp_err(input int code);
    if (code > 9) return 8'h40;
    return seg_tab[code];
  endfunction

  task automatic align(input int m);
    int n = 0;
    do begin
      @(negedge clk_1khz);
      n++;
    end while ((cyc % 10) != m && n < 20);
  endtask

  // Records one full scan period; bad counts cycles off the slot pattern.
  task automatic capture(output logic [7:0] ones, output logic [7:0] tens, output int bad);
    logic [1:0] want_sig;
    bad  = 0;
    ones = 8'hxx;
    tens = 8'hxx;
    align(1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk_1khz);
      if (i == 0) ones = smg_data;
      if (i == 5) tens = smg_data;
      want_sig = (i < 4) ? 2'b10 : ((i == 4 || i == 9) ? 2'b00 : 2'b01);
      if (smg_sig !== want_sig) bad++;
      if (i < 4 && smg_data !== ones) bad++;
      if (i > 4 && i < 9 && smg_data !== tens) bad++;
      if ((i == 4 || i == 9) && smg_data !== 8'h00) bad++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] o, t;
    int b;
    rst = 1'b0;
    temp_val = 7'd26;
    set_req = 1'b0;
    set_val = '0;
    err_req = 1'b0;
    err_code = '0;
    repeat (3) @(negedge clk_1khz);
    n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL reset_grant got=%b want=001", grant); end
    n_cmp++; if (smg_sig !== 2'b00) begin n_bad++; $display("FAIL reset_sig got=%b want=00", smg_sig); end
    n_cmp++; if (smg_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got=%h want=00", smg_data); end
    rst = 1'b1;
    capture(o, t, b);
    n_cmp++; if (o !== 8'h3F) begin n_bad++; $display("FAIL reset_first_ones got=%h want=3f", o); end
    n_cmp++; if (t !== 8'h5B) begin n_bad++; $display("FAIL reset_first_tens got=%h want=5b", t); end
    n_cmp++; if (b !== 0) begin n_bad++; $display("FAIL reset_scan_shape got=%0d want=0", b); end
    capture(o, t, b);
    n_cmp++; if (o !== 8'h7D) begin n_bad++; $display("FAIL reset_26_ones got=%h want=7d", o); end
    n_cmp++; if (t !== 8'h5B) begin n_bad++; $display("FAIL reset_26_tens got=%h want=5b", t); end
  endtask

  task automatic test_temp_display();
    int vals [12] = '{26, 7, 0, 99, 120, 127, 10, 100, 0, 0, 0, 0};
    logic [7:0] o, t;
    int b;
    for (int i = 8; i < 12; i++) vals[i] = $urandom_range(0, 127);
    foreach (vals[i]) begin
      temp_val = 7'(vals[i]);
      repeat (25) @(negedge clk_1khz);
      capture(o, t, b);
      n_cmp++; if (o !== exp_ones(vals[i])) begin n_bad++; $display("FAIL temp_ones v=%0d got=%h want=%h", vals[i], o, exp_ones(vals[i])); end
      n_cmp++; if (t !== exp_tens(vals[i])) begin n_bad++; $display("FAIL temp_tens v=%0d got=%h want=%h", vals[i], t, exp_tens(vals[i])); end
      n_cmp++; if (b !== 0) begin n_bad++; $display("FAIL temp_scan_shape v=%0d got=%0d want=0", vals[i], b); end
    end
  endtask

  // 99 takes 11 cycles from its sampling edge k to commit at edge k+11.
  task automatic test_latency();
    temp_val = 7'd50;
    repeat (30) @(negedge clk_1khz);
    align(9);
    temp_val = 7'd99;
    align(1);
    align(1);
    n_cmp++; if (smg_data !== 8'h3F) begin n_bad++; $display("FAIL lat_commit_edge got=%h want=3f", smg_data); end
    align(1);
    n_cmp++; if (smg_data !== 8'h6F) begin n_bad++; $display("FAIL lat_after_ones got=%h want=6f", smg_data); end
    align(6);
    n_cmp++; if (smg_data !== 8'h6F) begin n_bad++; $display("FAIL lat_after_tens got=%h want=6f", smg_data); end
    temp_val = 7'd50;
    repeat (30) @(negedge clk_1khz);
    align(8);
    temp_val = 7'd99;
    align(1);
    align(1);
    n_cmp++; if (smg_data !== 8'h6F) begin n_bad++; $display("FAIL lat_next_edge got=%h want=6f", smg_data); end
  endtask

  task automatic test_set_hold();
    logic [7:0] o, t;
    int b, c0, t_on, t_off;
    t_on = -1;
    t_off = -1;
    temp_val = 7'd42;
    set_val = 7'd30;
    set_req = 1'b1;
    c0 = cyc;
    @(negedge clk_1khz);
    set_req = 1'b0;
    repeat (40) begin
      if (grant === 3'b010 && t_on < 0) t_on = cyc;
      @(negedge clk_1khz);
    end
    capture(o, t, b);
    n_cmp++; if (o !== 8'h3F) begin n_bad++; $display("FAIL set_ones got=%h want=3f", o); end
    n_cmp++; if (t !== 8'h4F) begin n_bad++; $display("FAIL set_tens got=%h want=4f", t); end
    for (int i = 0; i < 2200 && t_off < 0; i++) begin
      @(negedge clk_1khz);
      n_cmp++; if (grant !== m_owner) begin n_bad++; $display("FAIL set_grant cyc=%0d got=%b want=%b", cyc, grant, m_owner); end
      if (grant !== 3'b010) t_off = cyc;
    end
    n_cmp++; if (t_on !== c0 + 1) begin n_bad++; $display("FAIL set_grant_latency got=%0d want=%0d", t_on, c0 + 1); end
    n_cmp++; if (t_off - t_on !== HOLD) begin n_bad++; $display("FAIL set_hold_len got=%0d want=%0d", t_off - t_on, HOLD); end
    n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL set_release got=%b want=001", grant); end
  endtask

  task automatic test_err_preempt();
    logic [7:0] o, t;
    int b, sv, ec;
    sv = $urandom_range(0, 99);
    set_val = 7'(sv);
    set_req = 1'b1;
    @(negedge clk_1khz);
    n_cmp++; if (grant !== 3'b010) begin n_bad++; $display("FAIL err_set_grant got=%b want=010", grant); end
    repeat (40) @(negedge clk_1khz);
    err_code = 4'd3;
    err_req = 1'b1;
    @(negedge clk_1khz);
    n_cmp++; if (grant !== 3'b100) begin n_bad++; $display("FAIL err_preempt got=%b want=100", grant); end
    repeat (11) @(negedge clk_1khz);
    capture(o, t, b);
    n_cmp++; if (o !== 8'h4F) begin n_bad++; $display("FAIL err_e3_ones got=%h want=4f", o); end
    n_cmp++; if (t !== 8'h79) begin n_bad++; $display("FAIL err_e3_tens got=%h want=79", t); end
    ec = $urandom_range(10, 15);
    err_code = 4'(ec);
    repeat (2) @(negedge clk_1khz);
    capture(o, t, b);
    n_cmp++; if (o !== exp_err(ec)) begin n_bad++; $display("FAIL err_dash_ones code=%0d got=%h want=%h", ec, o, exp_err(ec)); end
    n_cmp++; if (t !== 8'h79) begin n_bad++; $display("FAIL err_dash_tens got=%h want=79", t); end
    repeat (HOLD) begin
      @(negedge clk_1khz);
      n_cmp++; if (grant !== m_owner) begin n_bad++; $display("FAIL err_hold_grant cyc=%0d got=%b want=%b", cyc, grant, m_owner); end
    end
    err_req = 1'b0;
    @(negedge clk_1khz);
    n_cmp++; if (grant !== 3'b010) begin n_bad++; $display("FAIL err_to_set got=%b want=010", grant); end
    repeat (25) @(negedge clk_1khz);
    capture(o, t, b);
    n_cmp++; if (o !== exp_ones(sv)) begin n_bad++; $display("FAIL err_set_ones v=%0d got=%h want=%h", sv, o, exp_ones(sv)); end
    n_cmp++; if (t !== exp_tens(sv)) begin n_bad++; $display("FAIL err_set_tens v=%0d got=%h want=%h", sv, t, exp_tens(sv)); end
    set_req = 1'b0;
    repeat (HOLD + 100) begin
      @(negedge clk_1khz);
      n_cmp++; if (grant !== m_owner) begin n_bad++; $display("FAIL err_fresh_hold cyc=%0d got=%b want=%b", cyc, grant, m_owner); end
    end
    n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL err_back_temp got=%b want=001", grant); end
  endtask

  task automatic test_simultaneous();
    set_req = 1'b1;
    err_req = 1'b1;
    err_code = 4'd7;
    @(negedge clk_1khz);
    n_cmp++; if (grant !== 3'b100) begin n_bad++; $display("FAIL simul_grant got=%b want=100", grant); end
    set_req = 1'b0;
    repeat (5) @(negedge clk_1khz);
    err_req = 1'b0;
    repeat (HOLD + 50) begin
      @(negedge clk_1khz);
      n_cmp++; if (grant !== m_owner) begin n_bad++; $display("FAIL simul_track cyc=%0d got=%b want=%b", cyc, grant, m_owner); end
    end
    n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL simul_lost_req got=%b want=001", grant); end
  endtask

  task automatic test_random();
    int dur;
    for (int s = 0; s < 10; s++) begin
      set_req = 1'($urandom_range(0, 1));
      err_req = ($urandom_range(0, 3) == 0);
      set_val = 7'($urandom_range(0, 127));
      temp_val = 7'($urandom_range(0, 127));
      err_code = 4'($urandom);
      dur = $urandom_range(1, 1200);
      repeat (dur) begin
        @(negedge clk_1khz);
        n_cmp++; if (grant !== m_owner) begin n_bad++; $display("FAIL rand_grant cyc=%0d got=%b want=%b", cyc, grant, m_owner); end
      end
    end
    set_req = 1'b0;
    err_req = 1'b0;
    repeat (HOLD + 50) begin
      @(negedge clk_1khz);
      n_cmp++; if (grant !== m_owner) begin n_bad++; $display("FAIL rand_drain cyc=%0d got=%b want=%b", cyc, grant, m_owner); end
    end
  endtask

  task automatic test_reset_midconv();
    temp_val = 7'd20;
    repeat (30) @(negedge clk_1khz);
    temp_val = 7'd85;
    repeat (3) @(negedge clk_1khz);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (grant !== 3'b001) begin n_bad++; $display("FAIL midconv_grant got=%b want=001", grant); end
    n_cmp++; if (smg_sig !== 2'b00) begin n_bad++; $display("FAIL midconv_sig got=%b want=00", smg_sig); end
    n_cmp++; if (smg_data !== 8'h00) begin n_bad++; $display("FAIL midconv_data got=%h want=00", smg_data); end
    repeat (3) @(negedge clk_1khz);
    rst = 1'b1;
    align(1);
    n_cmp++; if (smg_data !== 8'h3F) begin n_bad++; $display("FAIL midconv_zero_ones got=%h want=3f", smg_data); end
    align(6);
    n_cmp++; if (smg_sig !== 2'b01 || smg_data !== 8'h00) begin n_bad++; $display("FAIL midconv_blank_tens got=%b/%h want=01/00", smg_sig, smg_data); end
    align(1);
    n_cmp++; if (smg_data !== 8'h3F) begin n_bad++; $display("FAIL midconv_commit_edge got=%h want=3f", smg_data); end
    align(1);
    n_cmp++; if (smg_data !== 8'h6D) begin n_bad++; $display("FAIL midconv_85_ones got=%h want=6d", smg_data); end
    align(6);
    n_cmp++; if (smg_data !== 8'h7F) begin n_bad++; $display("FAIL midconv_85_tens got=%h want=7f", smg_data); end
  endtask

  initial begin
    test_reset();
    test_temp_display();
    test_latency();
    test_set_hold();
    test_err_preempt();
    test_simultaneous();
    test_random();
    test_reset_midconv();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
